// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - 4-source interrupt controller with PEND/MASK/CAUSE/CTRL registers and REQ/SERVICE handshake FSM
// Optional IRQ_CTRL_EDGE_DETECT_EN: synchronised rising-edge events with sticky W1C PEND (default: level mode)
module irq_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  src_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        super_i,
  output logic        irq_out_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_MASK  = 2'd1;
  localparam logic [1:0] REG_CAUSE = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  logic [3:0] pend_q, pend_d;
  logic [3:0] mask_q, mask_d;
  logic       gie_q, gie_d;
  logic [1:0] state_q, state_d;
  logic       irq_q, irq_d;

  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_en;
  logic [3:0] masked;
  logic       valid;
  logic [1:0] idx;
  logic [31:0] cause;
  logic       unused_bits;

  assign sel         = (addr_i[31:4] == 28'h4000003);
  assign reg_idx     = addr_i[3:2];
  assign wr_en       = wr_i & sel;
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:4]};

  assign masked = pend_q & mask_q;
  assign valid  = |masked;

  always_comb begin
    idx = 2'd0;
    casez (masked)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign cause = {29'b0, valid, idx};

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] event_w, clr_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 4'b0;
      sync2_q <= 4'b0;
      prev_q  <= 4'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A fresh event on the same edge as its W1C wins, so no edge is ever lost.
  assign event_w = sync2_q & ~prev_q;
  assign clr_w   = (wr_en && reg_idx == REG_PEND) ? wdata_i[3:0] : 4'b0;
  assign pend_d  = (pend_q & ~clr_w) | event_w;
`else
  assign pend_d = src_i;
`endif

  assign mask_d = (wr_en && reg_idx == REG_MASK) ? wdata_i[3:0] : mask_q;
  assign gie_d  = (wr_en && reg_idx == REG_CTRL) ? wdata_i[0]   : gie_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 4'b0;
      mask_q <= 4'b0;
      gie_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      gie_q  <= gie_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  // No nesting: SERVICE only leaves via IDLE once the handler drops kernel mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && valid && !super_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (super_i)                 state_d = ST_SERVICE;
        else if (!gie_q || !valid)   state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (!super_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_d = (state_d == ST_REQ);
  end

  assign irq_out_o = irq_q;

  always_comb begin
    rdata_o = 32'b0;
    if (rd_i && sel) begin
      case (reg_idx)
        REG_PEND:  rdata_o = {28'b0, pend_q};
        REG_MASK:  rdata_o = {28'b0, mask_q};
        REG_CAUSE: rdata_o = cause;
        REG_CTRL:  rdata_o = {29'b0, state_q, gie_q};
        default:   rdata_o = 32'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl against a behavioural register/FSM model
module tb_irq_ctrl;

`ifdef IRQ_CTRL_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam int LAT = EDGE ? 3 : 1;

  localparam logic [31:0] A_PEND  = 32'h4000_0030;
  localparam logic [31:0] A_MASK  = 32'h4000_0034;
  localparam logic [31:0] A_CAUSE = 32'h4000_0038;
  localparam logic [31:0] A_CTRL  = 32'h4000_003C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src;
  logic        rd, wr, sup;
  logic [31:0] addr, wdata, rdata;
  logic        irq;

  int n_pass = 0;
  int n_total = 0;

  irq_ctrl dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .src_i     (src),
    .rd_i      (rd),
    .wr_i      (wr),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .super_i   (sup),
    .irq_out_o (irq)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: registers, source history and handshake state by rule.
  bit [3:0] m_pend, m_mask, h1, h2, h3;
  bit       m_gie, m_irq;
  int       m_state;

  function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
    bit [3:0] mp;
    int       lo;
    if (!rst_n || !r || a[31:4] != 28'h4000003) return 32'h0;
    mp = m_pend & m_mask;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (mp[i]) lo = i;
    case (a[3:2])
      2'd0:    return {28'b0, m_pend};
      2'd1:    return {28'b0, m_mask};
      2'd2:    return {29'b0, (mp != 0), lo[1:0]};
      default: return {29'b0, m_state[1:0], m_gie};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit [3:0] ev, clr, mp;
    bit       sel;
    int       ns;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_gie = 0; m_irq = 0; m_state = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      sel = (addr[31:4] == 28'h4000003);
      mp  = m_pend & m_mask;
      ns  = m_state;
      case (m_state)
        0: if (m_gie && mp != 0 && !sup) ns = 1;
        1: if (sup) ns = 2; else if (!m_gie || mp == 0) ns = 0;
        2: if (!sup) ns = 0;
        default: ns = 0;
      endcase
      if (EDGE) begin
        ev  = h2 & ~h3;
        clr = (wr && sel && addr[3:2] == 2'd0) ? wdata[3:0] : 4'h0;
        m_pend = (m_pend & ~clr) | ev;
        h3 = h2; h2 = h1; h1 = src;
      end else begin
        m_pend = src;
      end
      if (wr && sel && addr[3:2] == 2'd1) m_mask = wdata[3:0];
      if (wr && sel && addr[3:2] == 2'd3) m_gie  = wdata[0];
      m_state = ns;
      m_irq   = (ns == 1);
    end
  end

  always @(negedge clk) begin
    chk("irq_out_vs_model", {31'b0, irq}, {31'b0, m_irq});
    chk("rdata_vs_model", rdata, m_read(rd, addr));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cyc(1);
    wr = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk(nm, rdata, exp);
    rd = 1'b0; addr = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; src = 4'h0; rd = 1'b0; wr = 1'b0; sup = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    cyc(3);
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    rd_chk("rdata_in_reset", A_CTRL, 32'h0);
    rst_n = 1'b1;
    cyc(1);
    rd_chk("pend_reset", A_PEND, 32'h0);
    rd_chk("mask_reset", A_MASK, 32'h0);
    rd_chk("cause_reset", A_CAUSE, 32'h0);
    rd_chk("ctrl_reset", A_CTRL, 32'h0);

    // first interrupt latency and CAUSE
    wr_reg(A_MASK, 32'h1);
    wr_reg(A_CTRL, 32'h1);
    src = 4'h1;
    cyc(LAT);
    chk("irq_before_latency", {31'b0, irq}, 32'h0);
    cyc(1);
    chk("irq_at_latency", {31'b0, irq}, 32'h1);
    rd_chk("cause_src0", A_CAUSE, 32'h4);

    // priority and W1C
    src = 4'h0;
    cyc(LAT + 1);
    wr_reg(A_PEND, 32'hF);
    wr_reg(A_MASK, 32'hF);
    src = 4'hA;
    cyc(LAT + 1);
    rd_chk("cause_src_a", A_CAUSE, 32'h5);
    wr_reg(A_PEND, 32'h2);
    cyc(1);
    rd_chk("cause_after_w1c", A_CAUSE, EDGE ? 32'h7 : 32'h5);

    // REQ -> SERVICE -> IDLE -> REQ
    rd_chk("ctrl_req", A_CTRL, 32'h3);
    sup = 1'b1;
    cyc(1);
    rd_chk("ctrl_service", A_CTRL, 32'h5);
    chk("irq_service", {31'b0, irq}, 32'h0);
    sup = 1'b0;
    cyc(1);
    rd_chk("ctrl_idle", A_CTRL, 32'h1);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    cyc(1);
    rd_chk("ctrl_req_again", A_CTRL, 32'h3);
    chk("irq_req_again", {31'b0, irq}, 32'h1);

    // event latched while in kernel mode
    sup = 1'b1;
    cyc(1);
    src = 4'h0;
    cyc(LAT + 1);
    wr_reg(A_PEND, 32'hF);
    src = 4'h4;
    cyc(LAT + 3);
    chk("irq_held_super", {31'b0, irq}, 32'h0);
    rd_chk("pend_latched", A_PEND, 32'h4);
    rd_chk("ctrl_still_service", A_CTRL, 32'h5);
    sup = 1'b0;
    cyc(1);
    chk("irq_one_edge_after", {31'b0, irq}, 32'h0);
    cyc(1);
    chk("irq_two_edges_after", {31'b0, irq}, 32'h1);

    // set beats clear on the same edge
    src = 4'h6;
    cyc(2);
    wr_reg(A_PEND, 32'h2);
    rd_chk("pend_set_wins", A_PEND, 32'h6);
    wr_reg(A_PEND, 32'h2);
    rd_chk("pend_w1c_alone", A_PEND, EDGE ? 32'h4 : 32'h6);

    // async reset during REQ
    cyc(2);
    chk("irq_before_reset", {31'b0, irq}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("irq_async_reset", {31'b0, irq}, 32'h0);
    rd_chk("pend_async_reset", A_PEND, 32'h0);
    rd_chk("mask_async_reset", A_MASK, 32'h0);
    rd_chk("cause_async_reset", A_CAUSE, 32'h0);
    rd_chk("ctrl_async_reset", A_CTRL, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // randomized traffic checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) src = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sup = ~sup;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) addr = $urandom;
      else addr = 32'h4000_0030 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      if (addr[3:2] == 2'd3) wdata[0] = ($urandom_range(0, 3) != 0);
      if (i % 700 == 350) begin
        #10 rst_n = 1'b0;
        #20 rst_n = 1'b1;
      end
      cyc(1);
    end
    rd = 1'b0; wr = 1'b0;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 src  input  4  interrupt sources: [0] timer, [1] UART rx, [2] UART tx done, [3] switch; index 0 is highest priority.
REQ-004 rd  input  1  bus read strobe.
REQ-005 wr  input  1  bus write strobe.
REQ-006 addr  input  32  byte address from ALU output.
REQ-007 wdata  input  32  store data.
REQ-008 rdata  output  32  read data; all-zero when not selected or rd=0 (wired-OR data bus).
REQ-009 super  input  1  CPU in kernel mode (PC[31]).
REQ-010 irq_out  output  1  registered interrupt request to control unit.

Function
REQ-011 Block SHALL be selected when addr[31:4]==0x4000003; addr[3:2] selects register; addr[1:0] ignored.
REQ-012 Register map SHALL be: 0x40000030 PEND[3:0] (R/W1C), 0x34 MASK[3:0] (RW), 0x38 CAUSE (RO), 0x3C CTRL (bit0 GIE RW, bits[2:1] FSM state RO).
REQ-013 Reads SHALL be combinational, zero-extended to 32 bits.
REQ-014 CAUSE SHALL be {29'b0, valid, idx[1:0]}: valid=|(PEND&MASK), idx=lowest set bit index of PEND&MASK, 0 when none valid.
REQ-015 PEND bit SHALL set on a source event; a write to PEND SHALL clear bits where wdata=1; a set and a clear on the same bit in the same cycle SHALL leave it set.
REQ-016 Writes to MASK SHALL take wdata[3:0]; writes to CTRL SHALL take wdata[0] into GIE; writes to CAUSE SHALL be ignored.
REQ-017 FSM states SHALL be IDLE=0, REQ=1, SERVICE=2 (encoding visible in CTRL[2:1]).
REQ-018 IDLE->REQ when GIE & |(PEND&MASK) & ~super.
REQ-019 REQ->SERVICE when super=1; REQ->IDLE when super=0 and either GIE=0 or (PEND&MASK)==0 (request withdrawn).
REQ-020 SERVICE->IDLE when super=0 (handler returned); no nesting: no request is raised while in SERVICE.
REQ-021 irq_out SHALL be a flop equal to 1 exactly while state==REQ.
REQ-022 A pending interrupt arriving while super=1 SHALL stay latched in PEND and raise irq_out only after super returns to 0.
REQ-023 Level-mode latency: src high before edge k -> PEND set after edge k -> irq_out=1 after edge k+1.
REQ-024 Unused state encoding 3 SHALL return to IDLE on next edge.

Reset
REQ-025 Reset_n=0 SHALL asynchronously force PEND=0, MASK=0, GIE=0, state=IDLE, irq_out=0, and all synchroniser/edge flops to 0, including during REQ or SERVICE.
REQ-026 rdata SHALL be 0 while reset is asserted.

Configuration
REQ-027 Macro IRQ_CTRL_EDGE_DETECT_EN defined: each src passes a 2-flop synchroniser plus a previous-value flop; event = rising edge; PEND is sticky until W1C; src rising before edge k -> PEND after edge k+2 -> irq_out after edge k+3.
REQ-028 Macro undefined: level mode; PEND SHALL be loaded with src every cycle; W1C writes have no effect; event = src high.

Verification
REQ-029 Reset, then MASK=0x1, CTRL=0x1, src[0] rises with super=0 -> irq_out=1 at latency of REQ-023/027; CAUSE=0x4.
REQ-030 src=0xA with MASK=0xF, GIE=1 -> CAUSE=0x5 (idx 1); W1C 0x2 (edge mode) -> CAUSE=0x7 (idx 3).
REQ-031 State REQ, drive super=1 -> next edge state=SERVICE, irq_out=0; drive super=0 -> IDLE; if PEND still masked-valid -> REQ again one edge later.
REQ-032 super=1 throughout, src[2] event -> irq_out stays 0, PEND[2]=1; super drops -> irq_out=1 two edges later.
REQ-033 Edge mode: W1C of PEND[1] on the same edge as a new src[1] event -> PEND[1]=1.
REQ-034 Reset_n pulsed low while state=REQ -> irq_out=0 immediately, all registers read 0, rdata=0 for any addr.
